// File: rtl/poly_sub_share_lanes.sv
// -----------------------------------------------------------------------------
// poly_sub_share_lanes
//
// Lane-parallel modular subtraction stage for the masked Kyber decryption path
// (mp = v - INTT(s^T u), carried as two arithmetic shares). For each word of
// LANES coefficients it produces:
//   share 1: sub = (v - mp1) mod q
//   share 2: neg = (-mp2)    mod q
// Inputs need not be canonical: v lanes are reduced with one conditional
// subtract, mp lanes with an exact Barrett reduction valid for all MP_W-bit
// values. Results are registered with a one-cycle latency and a valid flag.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset (clears outputs and out_valid)
//   in_valid    capture the input word on this clock edge
//   v_coeffs    LANES x V_W  v word, lane i at [V_W*i +: V_W], lane 0 = LSBs
//   mp1_coeffs  LANES x MP_W mp share 1, lane i at [MP_W*i +: MP_W]
//   mp2_coeffs  LANES x MP_W mp share 2, same packing
//   out_valid   result registers hold a newly computed word
//   sub_coeffs  LANES x MP_W (v - mp1) mod q, zero-extended lanes
//   neg_coeffs  LANES x MP_W (-mp2) mod q, zero-extended lanes
// -----------------------------------------------------------------------------
module poly_sub_share_lanes #(
  parameter int KYBER_Q = 3329,
  parameter int LANES   = 8,
  parameter int V_W     = 12,
  parameter int MP_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [LANES*V_W-1:0]    v_coeffs,
  input  logic [LANES*MP_W-1:0]   mp1_coeffs,
  input  logic [LANES*MP_W-1:0]   mp2_coeffs,
  output logic                    out_valid,
  output logic [LANES*MP_W-1:0]   sub_coeffs,
  output logic [LANES*MP_W-1:0]   neg_coeffs
);

  // Width of a canonical residue in [0, q-1].
  localparam int R_W = $clog2(KYBER_Q);

  // Barrett constants: m = floor(2^BK / q). With BK = 24 and 16-bit inputs the
  // quotient estimate is low by at most one, so a single correction step
  // yields the exact residue for every input value.
  localparam int BK = 24;
  localparam int BM = (1 << BK) / KYBER_Q;
  localparam int PW = MP_W + BK;

  localparam logic [MP_W-1:0] Q_MP = MP_W'(KYBER_Q);
  localparam logic [V_W-1:0]  Q_V  = V_W'(KYBER_Q);
  localparam logic [R_W:0]    Q_D  = (R_W + 1)'(KYBER_Q);
  localparam logic [R_W-1:0]  Q_R  = R_W'(KYBER_Q);

  // v lanes are at most 2^V_W - 1 < 2q, so one conditional subtract suffices.
  function automatic logic [R_W-1:0] reduce_v(input logic [V_W-1:0] x);
    logic [V_W-1:0] r;
    r = x;
    if (x >= Q_V) r = x - Q_V;
    return R_W'(r);
  endfunction

  // Exact mod-q reduction of a full MP_W-bit value.
  function automatic logic [R_W-1:0] reduce_mp(input logic [MP_W-1:0] x);
    logic [PW-1:0]   prod;
    logic [MP_W-1:0] qe;
    logic [MP_W-1:0] r;
    prod = PW'(x) * PW'(BM);
    qe   = MP_W'(prod >> BK);
    // qe <= floor(x / q), so qe * q never exceeds x and cannot wrap.
    r    = x - MP_W'(qe * Q_MP);
    if (r >= Q_MP) r = r - Q_MP;
    return R_W'(r);
  endfunction

  logic [LANES*MP_W-1:0] sub_d;
  logic [LANES*MP_W-1:0] neg_d;

  always_comb begin
    logic [R_W-1:0] a;
    logic [R_W-1:0] b;
    logic [R_W-1:0] c;
    logic [R_W:0]   diff;
    logic [R_W-1:0] neg_r;
    // NOTE: every variable written here gets a value before any branch, so no
    // path can leave one unassigned and no latch is inferred.
    sub_d = '0;
    neg_d = '0;
    a     = '0;
    b     = '0;
    c     = '0;
    diff  = '0;
    neg_r = '0;
    for (int i = 0; i < LANES; i++) begin
      a = reduce_v(v_coeffs[i*V_W +: V_W]);
      b = reduce_mp(mp1_coeffs[i*MP_W +: MP_W]);
      c = reduce_mp(mp2_coeffs[i*MP_W +: MP_W]);

      // One extra bit catches the borrow; adding q back restores [0, q-1].
      diff = {1'b0, a} - {1'b0, b};
      if (diff[R_W]) diff = diff + Q_D;

      neg_r = (c == '0) ? '0 : (Q_R - c);

      sub_d[i*MP_W +: MP_W] = MP_W'(diff[R_W-1:0]);
      neg_d[i*MP_W +: MP_W] = MP_W'(neg_r);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      sub_coeffs <= '0;
      neg_coeffs <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sub_coeffs <= sub_d;
        neg_coeffs <= neg_d;
      end
    end
  end

endmodule

// File: tb/tb_poly_sub_share_lanes.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for poly_sub_share_lanes. Expected values are
// hand-computed constants for q = 3329.
// -----------------------------------------------------------------------------
module tb_poly_sub_share_lanes;

  localparam int LANES = 8;
  localparam int V_W   = 12;
  localparam int MP_W  = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic [LANES*V_W-1:0]  v_coeffs;
  logic [LANES*MP_W-1:0] mp1_coeffs;
  logic [LANES*MP_W-1:0] mp2_coeffs;
  logic                  out_valid;
  logic [LANES*MP_W-1:0] sub_coeffs;
  logic [LANES*MP_W-1:0] neg_coeffs;

  int n_cmp = 0;
  int n_err = 0;

  poly_sub_share_lanes dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .v_coeffs   (v_coeffs),
    .mp1_coeffs (mp1_coeffs),
    .mp2_coeffs (mp2_coeffs),
    .out_valid  (out_valid),
    .sub_coeffs (sub_coeffs),
    .neg_coeffs (neg_coeffs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LANES*V_W-1:0] rep_v(input int val);
    logic [LANES*V_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*V_W +: V_W] = V_W'(val);
    return r;
  endfunction

  function automatic logic [LANES*MP_W-1:0] rep_mp(input int val);
    logic [LANES*MP_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*MP_W +: MP_W] = MP_W'(val);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int v, input int m1, input int m2);
    v_coeffs   = rep_v(v);
    mp1_coeffs = rep_mp(m1);
    mp2_coeffs = rep_mp(m2);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic vld, input int s, input int n);
    check({tag, ".valid"}, 128'(out_valid), 128'(vld));
    check({tag, ".sub"}, sub_coeffs, rep_mp(s));
    check({tag, ".neg"}, neg_coeffs, rep_mp(n));
  endtask

  initial begin
    logic [LANES*MP_W-1:0] exp_sub;

    // Reset held with random inputs and in_valid=1.
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    v_coeffs   = {$urandom, $urandom, $urandom};
    mp1_coeffs = {$urandom, $urandom, $urandom, $urandom};
    mp2_coeffs = {$urandom, $urandom, $urandom, $urandom};
    tick();
    tick();
    tick();
    check_out("reset", 1'b0, 0, 0);

    // Release with no valid input: nothing should appear.
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("post_reset_idle.valid", 128'(out_valid), 128'(0));

    // Basic: 5 - 3 = 2, -0 = 0.
    in_valid = 1'b1;
    drive(5, 3, 0);
    tick();
    check_out("basic", 1'b1, 2, 0);

    // Wrap: 0 - 1 = 3328, -1 = 3328.
    drive(0, 1, 1);
    tick();
    check_out("wrap", 1'b1, 3328, 3328);

    // Non-canonical zero: mp2 = q reduces to 0, v = q and mp1 = q too.
    drive(3329, 3329, 3329);
    tick();
    check_out("q_is_zero", 1'b1, 0, 0);

    // Unreduced maxima: 4095->766, 65535->2284.
    drive(4095, 65535, 65535);
    tick();
    check_out("unreduced", 1'b1, 1811, 1045);

    // Top of the canonical range: 3328 - 0, -(3328).
    drive(3328, 0, 3328);
    tick();
    check_out("canon_max", 1'b1, 3328, 1);

    // Lane ordering: only lanes 0 and 7 non-zero.
    v_coeffs   = '0;
    mp1_coeffs = '0;
    mp2_coeffs = '0;
    v_coeffs[11:0]     = 12'd100;
    v_coeffs[95:84]    = 12'd200;
    mp1_coeffs[15:0]   = 16'd50;
    mp1_coeffs[127:112] = 16'd300;
    exp_sub            = '0;
    exp_sub[15:0]      = 16'd50;
    exp_sub[127:112]   = 16'd3229;
    tick();
    check("lanes.valid", 128'(out_valid), 128'(1));
    check("lanes.sub", sub_coeffs, exp_sub);
    check("lanes.neg", neg_coeffs, '0);

    // Stream of 4 back-to-back words.
    drive(7, 2, 5);
    tick();
    check_out("stream0", 1'b1, 5, 3324);
    drive(3329, 3330, 6658);
    tick();
    check_out("stream1", 1'b1, 3328, 0);
    drive(4000, 10000, 3328);
    tick();
    check_out("stream2", 1'b1, 658, 1);
    drive(1, 1, 6659);
    tick();
    check_out("stream3", 1'b1, 0, 3328);

    // Idle: new inputs must be ignored, last result held.
    in_valid = 1'b0;
    drive(100, 0, 0);
    tick();
    check_out("hold0", 1'b0, 0, 3328);
    tick();
    check_out("hold1", 1'b0, 0, 3328);

    // Reset mid-stream clears outputs without waiting for a clock edge.
    in_valid = 1'b1;
    drive(7, 2, 5);
    tick();
    check_out("pre_rst", 1'b1, 5, 3324);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 0, 0);
    tick();
    check_out("mid_rst_held", 1'b0, 0, 0);

    // Recovery after reset.
    rst_n = 1'b1;
    drive(0, 1, 1);
    tick();
    check_out("recover", 1'b1, 3328, 3328);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
